// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM encoding and default sizing.
package spi_pkg;
   localparam int M_DEF           = 16;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int CB_W            = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the parallel transmit/receive side of the slave.
interface spi_slave_if
   import spi_pkg::*;
#(
   parameter int M = M_DEF
);
   logic            SCLK;
   logic            MOSI;
   logic            LOAD;
   logic            MISO;
   logic [M-1:0]    DI;
   logic            DI_we;
   logic            tx_ready;
   logic [M-1:0]    DO;
   logic            DO_valid;
   logic            DO_rd;
   logic            busy;
   logic [CB_W-1:0] cb_bit;
   logic            ovr;

   modport slave (
      input  SCLK, MOSI, LOAD, DI, DI_we, DO_rd,
      output MISO, tx_ready, DO, DO_valid, busy, cb_bit, ovr
   );

   modport master (
      output SCLK, MOSI, LOAD, DI, DI_we, DO_rd,
      input  MISO, tx_ready, DO, DO_valid, busy, cb_bit, ovr
   );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized value.
module spi_sync
   import spi_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync;
   logic              prev;

   // All flops clear to 0, so a line held low through reset never looks like a falling edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync[0] <= d;
         for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
         prev <= sync[STAGES-1];
      end
   end

   assign q    = sync[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by clk. Define SPI_SLAVE_OVR_DET_EN to enable
// receive-overrun detection on ovr (cleared by DO_rd); otherwise ovr is tied 0.
module spi_slave
   import spi_pkg::*;
#(
   parameter int M           = M_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input logic        clk,
   input logic        clr,
   spi_slave_if.slave bus
);
   localparam logic [CB_W-1:0] CB_FULL = CB_W'(M);

   state_t          state, state_nx;
   logic [M-1:0]    sr_stx, sr_srx, tx_buf, do_r;
   logic [CB_W-1:0] cb;
   logic            tx_rdy, do_vld;
   logic            start, capture, shift_en, busy;

   logic sclk_rise, sclk_fall, unused_sclk_q;
   logic mosi_q, unused_mosi_rise, unused_mosi_fall;
   logic load_q, load_rise, load_fall;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sclk (
      .clk(clk), .clr(clr), .d(bus.SCLK),
      .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_mosi (
      .clk(clk), .clr(clr), .d(bus.MOSI),
      .q(mosi_q), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_load (
      .clk(clk), .clr(clr), .d(bus.LOAD),
      .q(load_q), .rise(load_rise), .fall(load_fall)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load_fall) state_nx = SHIFT;
         SHIFT:   if (cb == CB_FULL) state_nx = DONE;
                  else if (load_rise) state_nx = IDLE;
         DONE:    if (load_q) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      start    = (state == IDLE) && load_fall;
      capture  = (state == SHIFT) && (cb == CB_FULL);
      shift_en = (state == SHIFT) && (cb != CB_FULL);
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sr_stx <= '0;
         sr_srx <= '0;
         tx_buf <= '0;
         do_r   <= '0;
         cb     <= '0;
         tx_rdy <= 1'b1;
         do_vld <= 1'b0;
      end else begin
         do_vld <= capture;
         if (start) begin
            sr_stx <= tx_rdy ? '0 : tx_buf;
            sr_srx <= '0;
            cb     <= '0;
            tx_rdy <= 1'b1;
         end else if (shift_en) begin
            if (sclk_rise) begin
               sr_srx <= {sr_srx[M-2:0], mosi_q};
               cb     <= cb + CB_W'(1);
            end
            if (sclk_fall) sr_stx <= {sr_stx[M-2:0], 1'b0};
         end
         if (capture) do_r <= sr_srx;
         // A write landing on the frame-start clock refills the buffer for the next frame.
         if (bus.DI_we && tx_rdy) begin
            tx_buf <= bus.DI;
            tx_rdy <= 1'b0;
         end
      end
   end

   assign bus.MISO     = sr_stx[M-1];
   assign bus.tx_ready = tx_rdy;
   assign bus.DO       = do_r;
   assign bus.DO_valid = do_vld;
   assign bus.busy     = busy;
   assign bus.cb_bit   = cb;

`ifdef SPI_SLAVE_OVR_DET_EN
   logic unacked, ovr_r;

   // An ack coinciding with a new word counts as acknowledging the old one.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         unacked <= 1'b0;
         ovr_r   <= 1'b0;
      end else if (bus.DO_rd) begin
         unacked <= capture;
         ovr_r   <= 1'b0;
      end else if (capture) begin
         unacked <= 1'b1;
         ovr_r   <= ovr_r | unacked;
      end
   end

   assign bus.ovr = ovr_r;
`else
   logic unused_do_rd;
   assign unused_do_rd = bus.DO_rd;
   assign bus.ovr      = 1'b0;
`endif
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: M, 16, word width in bits (2..64).
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth for SCLK/MOSI/LOAD.
REQ-003 clk  in  1  system clock, rising edge; Fclk SHALL be >= 8x SCLK frequency.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 SCLK  in  1  serial clock from master, asynchronous to clk.
REQ-006 MOSI  in  1  serial data from master, MSB first.
REQ-007 LOAD  in  1  frame strobe from master: high = idle/load, low = transfer in progress.
REQ-008 MISO  out  1  serial data to master, MSB first.
REQ-009 DI  in  M  transmit word.
REQ-010 DI_we  in  1  write DI into transmit buffer.
REQ-011 tx_ready  out  1  transmit buffer empty.
REQ-012 DO  out  M  last complete received word.
REQ-013 DO_valid  out  1  one-clk pulse: DO updated.
REQ-014 DO_rd  in  1  consumer acknowledges DO.
REQ-015 busy  out  1  high in SHIFT or DONE.
REQ-016 cb_bit  out  8  received-bit count in current frame.
REQ-017 ovr  out  1  sticky receive-overrun flag.

Function
REQ-018 SCLK, MOSI, LOAD SHALL each pass through a SYNC_STAGES flop synchronizer; edges are detected on synchronized values only.
REQ-019 FSM states IDLE, SHIFT, DONE; IDLE -> SHIFT on synchronized LOAD falling edge.
REQ-020 On IDLE->SHIFT: sr_STX <= tx buffer (zeros if tx_ready=1), tx_ready <= 1, cb_bit <= 0, sr_SRX <= 0.
REQ-021 MISO SHALL equal sr_STX[M-1] at all times (combinational from register).
REQ-022 SHIFT, synchronized SCLK rising edge: sr_SRX <= {sr_SRX[M-2:0], MOSI_sync}; cb_bit <= cb_bit+1.
REQ-023 SHIFT, synchronized SCLK falling edge: sr_STX <= sr_STX << 1 (zero fill).
REQ-024 When cb_bit reaches M after a rising edge: next clk DO <= sr_SRX, DO_valid = 1 for exactly one clk, state -> DONE; further SCLK edges ignored.
REQ-025 DONE -> IDLE on synchronized LOAD high.
REQ-026 SHIFT with synchronized LOAD rising before M bits: abort -> IDLE, no DO_valid, DO unchanged.
REQ-027 DI_we with tx_ready=1: buffer <= DI, tx_ready <= 0 next clk; DI_we with tx_ready=0: ignored.
REQ-028 DI_we in the same clk as frame start: current frame uses old buffer content; written word held for next frame, tx_ready = 0.
REQ-029 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.

Reset
REQ-030 clr SHALL asynchronously force: state IDLE, MISO/DO/DO_valid/cb_bit/ovr/shift registers 0, tx_ready 1, buffer 0.
REQ-031 LOAD synchronizer flops SHALL reset to 0 so that LOAD low at reset release does not start a frame; a frame starts only after LOAD is seen high then low.
REQ-032 clr mid-frame SHALL discard the partial word without DO_valid.

Configuration
REQ-033 Macro SPI_SLAVE_OVR_DET_EN defined: ovr sets when DO_valid fires while the previous DO is unacknowledged (no DO_rd since last DO_valid); ovr clears on DO_rd; DO is still overwritten.
REQ-034 Macro undefined: ovr constant 0, DO_rd ignored, no tracking logic.

Structure
REQ-035 Package spi_pkg SHALL hold the FSM state encoding, default M, and default SYNC_STAGES.
REQ-036 Sub-module spi_sync SHALL implement one synchronizer plus rise/fall edge detect, instantiated three times.

Verification
REQ-037 Master model, M=16, SCLK = Fclk/1000, DI=16'hA5C3 written pre-frame, MOSI word 16'h3C5A -> DO=16'h3C5A, one DO_valid pulse, master receives 16'hA5C3.
REQ-038 No DI_we before frame -> MISO 0 for all 16 bits, tx_ready stays 1.
REQ-039 LOAD raised after 7 SCLK periods -> state IDLE, no DO_valid, DO unchanged, next full frame correct.
REQ-040 clr asserted at bit 9 while LOAD low, released with LOAD still low -> no frame until LOAD high then low; next frame correct.
REQ-041 SPI_SLAVE_OVR_DET_EN defined, two frames without DO_rd -> ovr=1 after second DO_valid; DO_rd -> ovr=0; undefined -> ovr stays 0.
REQ-042 DI_we with DI=16'h1234 coincident with LOAD falling edge -> current frame sends old buffer, next frame sends 16'h1234.
